// File: rtl/ps2_keycode_rx_if.sv
// rtl/ps2_keycode_rx_if.sv - PS/2 line inputs and keycode receiver outputs
interface ps2_keycode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] codigo;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;

    // Host side: drives the PS/2 lines, observes decoded results
    modport master (
        output ps2_clk,
        output ps2_data,
        input  codigo,
        input  byte_data,
        input  byte_valid,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output codigo,
        output byte_data,
        output byte_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 frame receiver with held-key scan code decoder
module ps2_keycode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_keycode_rx_if.slave bus
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronizers: bit 1 is the output stage
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [CW-1:0] filt_cnt_q, filt_cnt_d;
    logic          sample_evt;
    logic          ps2_bit;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    logic [7:0]    codigo_q, codigo_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;

    // Synchronize both lines, then debounce the clock: it flips only after
    // the synchronized level has disagreed for FILTER_LEN cycles in a row
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], bus.ps2_clk};
        data_sync_d = {data_sync_q[0], bus.ps2_data};
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_clk_d = ~filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + CW'(1);
            end
        end
        sample_evt = filt_clk_q & ~filt_clk_d;
        ps2_bit    = data_sync_q[1];
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; any gap
    // longer than TIMEOUT_CYC inside a frame drops the partial byte
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = tmo_q + TW'(1);
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (sample_evt && !ps2_bit) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_evt) begin
                    shift_d   = {ps2_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sample_evt) begin
                    par_d   = ps2_bit;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_evt) begin
                    state_d = IDLE;
                    if (ps2_bit && (^{shift_q, par_q})) begin
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            if (sample_evt) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                tmo_d       = '0;
                state_d     = IDLE;
                frame_err_d = 1'b1;
            end
        end
    end

    // Key decoder: F0/E0 are prefixes; an extended key never touches codigo,
    // a break clears codigo only if it releases the key currently shown
    always_comb begin
        codigo_d = codigo_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        if (byte_valid_q) begin
            if (byte_data_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (byte_data_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                if (!ext_q) begin
                    if (brk_q) begin
                        if (byte_data_q == codigo_q) begin
                            codigo_d = 8'h00;
                        end
                    end else begin
                        codigo_d = byte_data_q;
                    end
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    // State registers; idle PS/2 lines are high, so synchronizers and filter reset to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            codigo_q     <= 8'h00;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            codigo_q     <= codigo_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
        end
    end

    assign bus.codigo     = codigo_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive clk cycles a synchronized ps2_clk level must hold before it is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 100000: maximum clk cycles between accepted PS/2 falling edges inside one frame (1 ms at 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz; the only clock.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 codigo  output  8  scan code of the key currently held; 8'h00 when no key is held; feeds the tone generator's codigo input directly.
REQ-008 byte_data  output  8  last correctly received raw byte.
REQ-009 byte_valid  output  1  one-cycle pulse when byte_data updates.
REQ-010 frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer before any other use.
REQ-012 Filtered ps2_clk SHALL change only after the synchronized level differs from it for FILTER_LEN consecutive cycles; a falling edge of the filtered clock is a "sample event".
REQ-013 Synchronized ps2_data SHALL be sampled on each sample event.
REQ-014 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on a sample event with data=0, go to DATA and clear the bit counter; with data=1, stay in IDLE with no error.
REQ-016 DATA: shift 8 bits LSB first; after the 8th bit go to PARITY.
REQ-017 PARITY: store the bit; go to STOP.
REQ-018 STOP: if stop bit=1 and the 9 bits (data+parity) have odd parity, load byte_data and pulse byte_valid one cycle after the stop sample event; otherwise pulse frame_err and leave byte_data unchanged; return to IDLE in both cases.
REQ-019 Timeout: in DATA, PARITY or STOP, if TIMEOUT_CYC cycles pass without a sample event, pulse frame_err and return to IDLE; the partial byte is discarded.
REQ-020 Key decoder on each byte_valid: 8'hF0 sets break_pend; 8'hE0 sets ext_pend; any other byte is a key byte.
REQ-021 Key byte with break_pend=1: if the byte equals codigo, set codigo to 8'h00; otherwise leave codigo unchanged; clear break_pend and ext_pend in both cases.
REQ-022 Key byte with break_pend=0 and ext_pend=0: set codigo to the byte (make code; a typematic repeat of the same key leaves the value unchanged).
REQ-023 Key byte with ext_pend=1 (extended key): codigo SHALL be unchanged; clear ext_pend and break_pend.
REQ-024 codigo SHALL update in the cycle after byte_valid.
REQ-025 frame_err SHALL NOT change break_pend, ext_pend or codigo.
REQ-026 Two consecutive 8'hF0 bytes SHALL leave break_pend=1.
REQ-027 A new make code received while another key is held SHALL replace codigo (last key wins).

Reset
REQ-028 While rst=1, all outputs SHALL be 0: codigo=8'h00, byte_data=8'h00, byte_valid=0, frame_err=0.
REQ-029 While rst=1, the FSM SHALL be in IDLE, break_pend=0, ext_pend=0, the filtered clock=1, and the synchronizers=1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no byte_valid or frame_err pulse.

Verification
REQ-031 Send frame 8'h1C (parity 0, stop 1) -> byte_valid pulses once; byte_data=8'h1C; codigo=8'h1C.
REQ-032 Send 8'h1C, then 8'hF0, then 8'h1C -> codigo ends at 8'h00; byte_valid pulses 3 times.
REQ-033 Hold 8'h15, then send 8'h1D, then F0 15 -> codigo=8'h1D and stays 8'h1D.
REQ-034 Send 8'h24 with the parity bit inverted -> one frame_err pulse, no byte_valid, codigo unchanged.
REQ-035 Stop ps2_clk after 4 data bits for more than TIMEOUT_CYC cycles -> one frame_err pulse; FSM in IDLE; the next good frame 8'h2D -> codigo=8'h2D.
REQ-036 Inject 3-cycle glitches on ps2_clk during a frame of 8'h43 with FILTER_LEN=8, then assert rst mid-frame -> glitches are ignored and 8'h43 is received; after rst, all outputs are 0 and the next frame is received normally.
